// File: rtl/reg_file_dumper_pkg.sv
// -----------------------------------------------------------------------------
// reg_file_dumper_pkg
// Shared definitions for the register-file dumper:
//   - dump_state_t : FSM state encoding (3 bits)
//   - NB_BYTE      : width of one transmitted symbol
//   - DBG_CMD_DUMP_REGS : debug-unit opcode that raises i_start on the dumper
// -----------------------------------------------------------------------------
package reg_file_dumper_pkg;

  localparam int NB_BYTE = 8;

  localparam logic [7:0] DBG_CMD_DUMP_REGS = 8'h52;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_SEND = 3'd2,
    ST_WAIT = 3'd3,
    ST_DONE = 3'd4
  } dump_state_t;

endpackage

// File: rtl/reg_file_dumper.sv
// -----------------------------------------------------------------------------
// reg_file_dumper
// Debug-side reader of the CPU register file. On i_start it walks addresses
// 0..NB_REG-1 through the combinational read port and streams every word to
// the UART transmitter as bytes, most significant byte first, using a
// start/done byte handshake.
//
// Optional build macro: DUMP_CHECKSUM_EN
//   When defined, a running XOR of all data bytes is sent as one extra byte
//   after the last data byte.
//
// Ports:
//   i_clk            system clock, all logic on posedge
//   i_rst            synchronous active-low reset
//   i_start          one-cycle dump request (honoured only in IDLE)
//   o_read_register  register-file read address
//   i_read_data      combinational read data for o_read_register
//   o_tx_data        byte to transmit, held from o_tx_start until i_tx_done
//   o_tx_start       one-cycle transmit start pulse
//   i_tx_done        one-cycle byte-finished pulse (sampled only in WAIT)
//   o_busy           high while a dump is in progress
//   o_done           one-cycle pulse when the dump is complete
// -----------------------------------------------------------------------------
module reg_file_dumper #(
  parameter int LEN     = 32,
  parameter int NB_REG  = 32,
  parameter int NB_ADDR = 5,
  parameter int NB_BYTE = reg_file_dumper_pkg::NB_BYTE
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  output logic [NB_ADDR-1:0] o_read_register,
  input  logic [LEN-1:0]     i_read_data,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  output logic               o_busy,
  output logic               o_done
);

  import reg_file_dumper_pkg::*;

  localparam int                 BPW       = LEN / NB_BYTE;
  localparam int                 CNT_W     = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [CNT_W-1:0]   LAST_BYTE = CNT_W'(BPW - 1);
  localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(NB_REG - 1);

  dump_state_t        r_state;
  dump_state_t        w_state_nxt;
  logic [NB_ADDR-1:0] r_addr;
  logic [NB_ADDR-1:0] w_addr_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [LEN-1:0]     r_shift;
  logic [LEN-1:0]     w_shift_nxt;
  logic [LEN-1:0]     w_shifted;
  logic [NB_BYTE-1:0] r_tx_data;
  logic [NB_BYTE-1:0] w_tx_data_nxt;
  logic               r_tx_start;
  logic               w_tx_start_nxt;
  logic               r_busy;
  logic               w_busy_nxt;
  logic               r_done;
  logic               w_done_nxt;

`ifdef DUMP_CHECKSUM_EN
  logic [NB_BYTE-1:0] r_csum;
  logic [NB_BYTE-1:0] w_csum_nxt;
  logic               r_csum_phase;     // the byte in flight is the checksum
  logic               w_csum_phase_nxt;

  function automatic logic [NB_BYTE-1:0] csum_fold(
    input logic [NB_BYTE-1:0] acc,
    input logic [NB_BYTE-1:0] data
  );
    return acc ^ data;
  endfunction
`endif

  assign w_shifted = r_shift << NB_BYTE;

  // Next-state and next-output decode; every output is registered below,
  // so the value computed here appears one cycle later.
  always_comb begin
    w_state_nxt    = r_state;
    w_addr_nxt     = r_addr;
    w_cnt_nxt      = r_cnt;
    w_shift_nxt    = r_shift;
    w_tx_data_nxt  = r_tx_data;
    w_tx_start_nxt = 1'b0;
    w_done_nxt     = 1'b0;
`ifdef DUMP_CHECKSUM_EN
    w_csum_nxt       = r_csum;
    w_csum_phase_nxt = r_csum_phase;
`endif
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ST_READ;
          w_addr_nxt  = '0;
          w_cnt_nxt   = '0;
`ifdef DUMP_CHECKSUM_EN
          w_csum_nxt       = '0;
          w_csum_phase_nxt = 1'b0;
`endif
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_READ: begin
        // Load the word and present its MSByte so o_tx_start fires in SEND.
        w_shift_nxt    = i_read_data;
        w_tx_data_nxt  = i_read_data[LEN-1 -: NB_BYTE];
        w_tx_start_nxt = 1'b1;
`ifdef DUMP_CHECKSUM_EN
        w_csum_nxt = csum_fold(r_csum, i_read_data[LEN-1 -: NB_BYTE]);
`endif
        w_state_nxt = ST_SEND;
      end
      ST_SEND: begin
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_tx_done) begin
`ifdef DUMP_CHECKSUM_EN
          if (r_csum_phase) begin
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
            w_addr_nxt  = '0;
          end else
`endif
          if (r_cnt != LAST_BYTE) begin
            w_shift_nxt    = w_shifted;
            w_tx_data_nxt  = w_shifted[LEN-1 -: NB_BYTE];
            w_tx_start_nxt = 1'b1;
            w_cnt_nxt      = r_cnt + CNT_W'(1);
`ifdef DUMP_CHECKSUM_EN
            w_csum_nxt = csum_fold(r_csum, w_shifted[LEN-1 -: NB_BYTE]);
`endif
            w_state_nxt = ST_SEND;
          end else if (r_addr != LAST_ADDR) begin
            w_addr_nxt  = r_addr + NB_ADDR'(1);
            w_cnt_nxt   = '0;
            w_state_nxt = ST_READ;
          end else begin
`ifdef DUMP_CHECKSUM_EN
            // Checksum already covers every data byte sent so far.
            w_tx_data_nxt    = r_csum;
            w_tx_start_nxt   = 1'b1;
            w_csum_phase_nxt = 1'b1;
            w_state_nxt      = ST_SEND;
`else
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
            w_addr_nxt  = '0;
`endif
          end
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt == ST_READ) || (w_state_nxt == ST_SEND) ||
                 (w_state_nxt == ST_WAIT);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      r_csum       <= '0;
      r_csum_phase <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_addr     <= w_addr_nxt;
      r_cnt      <= w_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_tx_start <= w_tx_start_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
`ifdef DUMP_CHECKSUM_EN
      r_csum       <= w_csum_nxt;
      r_csum_phase <= w_csum_phase_nxt;
`endif
    end
  end

  assign o_read_register = r_addr;
  assign o_tx_data       = r_tx_data;
  assign o_tx_start      = r_tx_start;
  assign o_busy          = r_busy;
  assign o_done          = r_done;

endmodule

// File: doc/reg_file_dumper.md
Name: reg_file_dumper

Overview:
- Debug-side reader for the CPU register file.
- On command, walks every register address through a combinational read port and streams each word as bytes to the UART transmitter.
- Uses a start/done byte handshake.
- Sits between the debug unit (issues i_start) and uart_tx. The pipeline is halted (register-file i_enable low) for the whole dump, so contents are stable.

Parameters:
- LEN, 32, register width in bits; must be a multiple of NB_BYTE.
- NB_REG, 32, number of registers dumped (addresses 0..NB_REG-1).
- NB_ADDR, 5, register address width; NB_REG <= 2**NB_ADDR.
- NB_BYTE, 8, transmitted symbol width.

Ports:
- i_clk  in  1  system clock, all logic on posedge.
- i_rst  in  1  reset; synchronous, active-low.
- i_start  in  1  one-cycle dump request from the debug unit.
- o_read_register  out  NB_ADDR  address driven to the register-file combinational read port.
- i_read_data  in  LEN  combinational read data for o_read_register.
- o_tx_data  out  NB_BYTE  byte to transmit; stable from o_tx_start until i_tx_done.
- o_tx_start  out  1  one-cycle pulse to start transmitting o_tx_data.
- i_tx_done  in  1  one-cycle pulse from the transmitter when the byte is finished.
- o_busy  out  1  high from the cycle after i_start is accepted until DONE.
- o_done  out  1  one-cycle pulse when the dump is complete.

Behaviour:
- Reset (i_rst==0 at posedge), including mid-dump:
  - state=IDLE.
  - o_read_register=0, o_tx_data=0, o_tx_start=0, o_busy=0, o_done=0.
  - Internal byte counter, shift register and checksum cleared.
  - Any byte in flight is abandoned.
- FSM states: IDLE, READ, SEND, WAIT, DONE.
- IDLE:
  - i_start=1 -> READ; address=0, byte count=0.
  - i_start is ignored in every other state.
- READ (1 cycle):
  - Capture i_read_data for the current o_read_register into the LEN-bit shift register -> SEND.
- SEND (1 cycle):
  - o_tx_start=1 and o_tx_data = shift register MSByte (big-endian, MSB first) -> WAIT.
- WAIT:
  - Hold o_tx_data. i_tx_done is sampled only in this state.
  - On i_tx_done, if not the last byte of the word (LEN/NB_BYTE bytes): shift left by NB_BYTE, byte count+1 -> SEND.
  - On i_tx_done, if last byte and address != NB_REG-1: address+1, byte count=0 -> READ.
  - On i_tx_done, if last byte and last address -> DONE.
- DONE (1 cycle): o_done=1, o_busy=0 -> IDLE; o_read_register returns to 0.
- Latency:
  - First o_tx_start is 2 cycles after the cycle i_start is sampled.
  - Next byte of the same word: o_tx_start 1 cycle after i_tx_done.
  - First byte of the next word: o_tx_start 2 cycles after i_tx_done.
- Total dump = NB_REG*LEN/NB_BYTE bytes (128 at defaults).
- Address never wraps; it stops at NB_REG-1.
- i_tx_done outside WAIT is ignored; i_start coincident with DONE is ignored.

Optional Feature:
- DUMP_CHECKSUM_EN defined:
  - Running XOR of every transmitted byte is kept.
  - After the last data byte, one extra SEND/WAIT pair transmits the checksum before DONE.
  - Total bytes = data bytes + 1.
- DUMP_CHECKSUM_EN not defined: no checksum logic, no extra byte.

Decomposition:
- Shared package holds:
  - FSM state encoding constants (IDLE, READ, SEND, WAIT, DONE; 3 bits).
  - NB_BYTE.
  - Debug command opcode that raises i_start.
- No sub-module: the FSM and datapath fit in one file. uart_tx stays a separate existing instance at integration.

Test Plan:
- Registers init r[n]=n, i_start pulse, transmitter model returns i_tx_done 5 cycles after each o_tx_start -> 128 bytes 00 00 00 00, 00 00 00 01 ... 00 00 00 1F; one o_done pulse; o_busy high throughout.
- Same dump, timing -> first o_tx_start exactly 2 cycles after i_start; intra-word gap 1 cycle after i_tx_done; inter-word gap 2 cycles.
- Set r1=0xDEADBEEF, DUMP_CHECKSUM_EN defined -> bytes 4..7 = DE AD BE EF; 129th byte = 0x23. With r[n]=n only, checksum byte = 0x00.
- Assert i_rst=0 during byte 10 -> next cycle all outputs 0, state IDLE. A new i_start restarts the dump at r0 byte 00.
- Pulse i_start and spurious i_tx_done while busy (in SEND/READ) -> ignored; byte sequence and count unchanged.
- Hold i_tx_done low 1000 cycles in WAIT -> o_tx_data stable, no further o_tx_start, o_busy stays 1.
